// File: rtl/siggen_pkg.sv
// Shared types and constants for the test signal generator.
package siggen_pkg;

  typedef enum logic [1:0] {
    IMPULSE = 2'd0,
    PULSE   = 2'd1,
    NOISE   = 2'd2,
    ALT     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PLAYING = 2'd2,
    GAP     = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit right-shifting Galois LFSR with synchronous seed load.
module lfsr16_galois
  import siggen_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'hACE1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        load_in,
  input  logic [15:0] seed_in,
  input  logic        advance_in,
  output logic [15:0] state_out
);

  logic [15:0] r_state;
  logic [15:0] w_shifted;

  assign w_shifted = r_state[0] ? ((r_state >> 1) ^ LFSR_TAPS) : (r_state >> 1);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= RESET_VAL;
    end else if (load_in) begin
      r_state <= seed_in;
    end else if (advance_in) begin
      r_state <= w_shifted;
    end
  end

  assign state_out = r_state;

endmodule

// File: rtl/test_signal_gen.sv
// Triggered excitation burst source (impulse/pulse/noise/alternating) on the sample grid.
// Define SIGGEN_REPEAT_EN to add repeat_in and the GAP state for looping bursts.
module test_signal_gen
  import siggen_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter int          LEN_W       = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          GAP_SAMPLES = 4800
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    step_in,
  input  logic                    trigger_in,
  input  logic                    abort_in,
  input  logic [1:0]              mode_in,
  input  logic [LEN_W-1:0]        length_in,
  input  logic signed [WIDTH-1:0] amplitude_in,
`ifdef SIGGEN_REPEAT_EN
  input  logic                    repeat_in,
`endif
  output logic                    busy_out,
  output logic                    start_out,
  output logic                    done_out,
  output logic signed [WIDTH-1:0] amp_out
);

  // state   | meaning
  // IDLE    | silent, waiting for trigger
  // ARMED   | parameters latched, first sample goes out on next step
  // PLAYING | emitting samples until remaining count is exhausted
  // GAP     | silent interval between repeated bursts

  localparam logic signed [WIDTH-1:0] AMP_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] AMP_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  // The done strobe already produces the first silent sample of the gap.
  if (GAP_SAMPLES < 2) begin : g_gap_check
    $error("GAP_SAMPLES must be at least 2");
  end

  state_e                  r_state, w_state_next;
  mode_e                   r_mode;
  logic [LEN_W-1:0]        r_len, r_rem, w_eff_len_m1;
  logic signed [WIDTH-1:0] r_amp, r_amp_out, w_neg_amp, w_sample;
  logic                    r_alt_neg, r_start, r_done;
  logic                    w_go, w_accept, w_emit_first, w_emit_next, w_last, w_emit;
  logic                    w_lfsr_load, w_lfsr_adv;
  logic [15:0]             w_lfsr;
  logic                    w_unused_lfsr;

`ifdef SIGGEN_REPEAT_EN
  localparam logic [15:0] GAP_LOAD = 16'(GAP_SAMPLES - 2);
  logic        r_repeat;
  logic [15:0] r_gap_cnt;
  logic        w_gap_done;
  assign w_gap_done  = (r_state == GAP) && w_go && (r_gap_cnt == '0);
  assign w_lfsr_load = w_accept || w_gap_done;
`else
  assign w_lfsr_load = w_accept;
`endif

  assign w_go         = step_in && !abort_in;
  assign w_accept     = (r_state == IDLE) && trigger_in && !abort_in;
  assign w_emit_first = (r_state == ARMED) && w_go;
  assign w_emit_next  = (r_state == PLAYING) && w_go && (r_rem != '0);
  assign w_last       = (r_state == PLAYING) && w_go && (r_rem == '0);
  assign w_emit       = w_emit_first || w_emit_next;
  assign w_lfsr_adv   = w_emit && (r_mode == NOISE);
  assign w_unused_lfsr = ^w_lfsr[15:1];

  assign w_neg_amp    = (r_amp == AMP_MIN) ? AMP_MAX : -r_amp;
  assign w_eff_len_m1 = ((r_mode == IMPULSE) || (r_len == '0)) ? '0 : r_len - LEN_W'(1);

  always_comb begin
    w_sample = r_amp;
    case (r_mode)
      NOISE:   w_sample = w_lfsr[0] ? r_amp : w_neg_amp;
      ALT:     w_sample = r_alt_neg ? w_neg_amp : r_amp;
      default: w_sample = r_amp;
    endcase
  end

  lfsr16_galois #(.RESET_VAL(LFSR_SEED)) u_lfsr (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .load_in    (w_lfsr_load),
    .seed_in    (LFSR_SEED),
    .advance_in (w_lfsr_adv),
    .state_out  (w_lfsr)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (abort_in) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (trigger_in) w_state_next = ARMED;
        ARMED:   if (step_in) w_state_next = PLAYING;
        PLAYING: begin
          if (step_in && (r_rem == '0)) begin
`ifdef SIGGEN_REPEAT_EN
            w_state_next = r_repeat ? GAP : IDLE;
`else
            w_state_next = IDLE;
`endif
          end
        end
`ifdef SIGGEN_REPEAT_EN
        GAP:     if (step_in && (r_gap_cnt == '0)) w_state_next = ARMED;
`endif
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_mode    <= IMPULSE;
      r_len     <= '0;
      r_amp     <= '0;
      r_rem     <= '0;
      r_alt_neg <= 1'b0;
      r_amp_out <= '0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
`ifdef SIGGEN_REPEAT_EN
      r_repeat  <= 1'b0;
      r_gap_cnt <= '0;
`endif
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      if (abort_in) begin
        r_amp_out <= '0;
      end else begin
        if (w_accept) begin
          r_mode    <= mode_e'(mode_in);
          r_len     <= length_in;
          r_amp     <= amplitude_in;
          r_alt_neg <= 1'b0;
`ifdef SIGGEN_REPEAT_EN
          r_repeat  <= repeat_in;
`endif
        end
        if (w_emit) begin
          r_amp_out <= w_sample;
          r_alt_neg <= ~r_alt_neg;
        end
        if (w_emit_first) begin
          r_start <= 1'b1;
          r_rem   <= w_eff_len_m1;
        end
        if (w_emit_next) r_rem <= r_rem - LEN_W'(1);
        if (w_last) begin
          r_amp_out <= '0;
          r_done    <= 1'b1;
`ifdef SIGGEN_REPEAT_EN
          r_gap_cnt <= GAP_LOAD;
`endif
        end
`ifdef SIGGEN_REPEAT_EN
        if ((r_state == GAP) && step_in) begin
          if (r_gap_cnt == '0) r_alt_neg <= 1'b0;
          else r_gap_cnt <= r_gap_cnt - 16'd1;
        end
`endif
      end
    end
  end

  always_comb begin
    busy_out  = (r_state != IDLE);
    start_out = r_start;
    done_out  = r_done;
    amp_out   = r_amp_out;
  end

endmodule

// File: tb/tb_test_signal_gen.sv
// Scoreboard bench for test_signal_gen: directed bursts, abort, async reset.
module tb_test_signal_gen;

  localparam int WIDTH = 16;
  localparam int LEN_W = 16;

  typedef struct {
    logic signed [WIDTH-1:0] amp;
    logic                    start;
    logic                    done;
    logic                    busy;
    string                   tag;
  } exp_t;

  logic                    clk_in = 1'b0;
  logic                    rst_in;
  logic                    step_in;
  logic                    trigger_in;
  logic                    abort_in;
  logic [1:0]              mode_in;
  logic [LEN_W-1:0]        length_in;
  logic signed [WIDTH-1:0] amplitude_in;
`ifdef SIGGEN_REPEAT_EN
  logic                    repeat_in;
`endif
  logic                    busy_out;
  logic                    start_out;
  logic                    done_out;
  logic signed [WIDTH-1:0] amp_out;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_in = ~clk_in;

  test_signal_gen #(
    .WIDTH       (WIDTH),
    .LEN_W       (LEN_W),
    .LFSR_SEED   (16'hACE1),
    .GAP_SAMPLES (2)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .step_in      (step_in),
    .trigger_in   (trigger_in),
    .abort_in     (abort_in),
    .mode_in      (mode_in),
    .length_in    (length_in),
    .amplitude_in (amplitude_in),
`ifdef SIGGEN_REPEAT_EN
    .repeat_in    (repeat_in),
`endif
    .busy_out     (busy_out),
    .start_out    (start_out),
    .done_out     (done_out),
    .amp_out      (amp_out)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic signed [WIDTH-1:0] neg_sat(input logic signed [WIDTH-1:0] a);
    if (a == -32768) return 16'sd32767;
    return -a;
  endfunction

  task automatic expect_out(input logic signed [WIDTH-1:0] amp, input logic start,
                            input logic done, input logic busy, input string tag);
    exp_t e;
    e.amp = amp; e.start = start; e.done = done; e.busy = busy; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    checks++;
    assert (q.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty got=%0d exp=>0", q.size());
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      assert (amp_out === e.amp) else begin
        failures++;
        $error("FAIL %s amp got=%0d exp=%0d", e.tag, amp_out, e.amp);
      end
      checks++;
      assert (start_out === e.start) else begin
        failures++;
        $error("FAIL %s start got=%0b exp=%0b", e.tag, start_out, e.start);
      end
      checks++;
      assert (done_out === e.done) else begin
        failures++;
        $error("FAIL %s done got=%0b exp=%0b", e.tag, done_out, e.done);
      end
      checks++;
      assert (busy_out === e.busy) else begin
        failures++;
        $error("FAIL %s busy got=%0b exp=%0b", e.tag, busy_out, e.busy);
      end
    end
  endtask

  task automatic clk1();
    @(posedge clk_in);
    #1;
  endtask

  // One step strobe, then one quiet cycle to show the start/done pulses are single-cycle.
  task automatic do_step(input logic signed [WIDTH-1:0] amp, input logic start,
                         input logic done, input logic busy, input string tag);
    expect_out(amp, start, done, busy, tag);
    step_in = 1'b1;
    clk1();
    step_in = 1'b0;
    check_front();
    expect_out(amp, 1'b0, 1'b0, busy, {tag, "_hold"});
    clk1();
    check_front();
  endtask

  task automatic do_trigger(input logic [1:0] mode, input logic [LEN_W-1:0] len,
                            input logic signed [WIDTH-1:0] amp, input logic step_too);
    mode_in = mode; length_in = len; amplitude_in = amp;
    trigger_in = 1'b1;
    step_in = step_too;
    expect_out('0, 1'b0, 1'b0, 1'b1, "armed");
    clk1();
    trigger_in = 1'b0;
    step_in = 1'b0;
    check_front();
    expect_out('0, 1'b0, 1'b0, 1'b1, "armed_wait");
    clk1();
    check_front();
  endtask

  task automatic run_burst(input logic [1:0] mode, input logic [LEN_W-1:0] len,
                           input logic signed [WIDTH-1:0] amp, input logic step_too,
                           input string tag);
    int n;
    logic [15:0] s;
    logic signed [WIDTH-1:0] v;
    do_trigger(mode, len, amp, step_too);
    n = (mode == 2'd0) ? 1 : ((len == 0) ? 1 : int'(len));
    s = 16'hACE1;
    for (int i = 0; i < n; i++) begin
      case (mode)
        2'd2:    v = s[0] ? amp : neg_sat(amp);
        2'd3:    v = (i % 2 == 0) ? amp : neg_sat(amp);
        default: v = amp;
      endcase
      if (mode == 2'd2) s = lfsr_next(s);
      do_step(v, (i == 0), 1'b0, 1'b1, $sformatf("%s_s%0d", tag, i + 1));
    end
    do_step('0, 1'b0, 1'b1, 1'b0, {tag, "_done"});
  endtask

  initial begin
    rst_in = 1'b1; step_in = 1'b0; trigger_in = 1'b0; abort_in = 1'b0;
    mode_in = 2'd0; length_in = '0; amplitude_in = '0;
`ifdef SIGGEN_REPEAT_EN
    repeat_in = 1'b0;
`endif
    #12;
    expect_out('0, 1'b0, 1'b0, 1'b0, "reset");
    check_front();
    #1 rst_in = 1'b0;
    clk1();

    // Impulse ignores length_in; third step stays silent
    run_burst(2'd0, 16'd50, 16'sd16384, 1'b0, "impulse");
    do_step('0, 1'b0, 1'b0, 1'b0, "impulse_after");

    run_burst(2'd1, 16'd4, 16'sd1000, 1'b0, "pulse4");
    run_burst(2'd1, 16'd0, 16'sd1000, 1'b0, "pulse0");

    // Noise twice: +100, -100, -100; step during trigger cycle is ignored
    run_burst(2'd2, 16'd3, 16'sd100, 1'b0, "noise_a");
    run_burst(2'd2, 16'd3, 16'sd100, 1'b1, "noise_b");

    run_burst(2'd3, 16'd3, -16'sd32768, 1'b0, "alt_sat");

    // Abort mid-burst while trigger is held and inputs change
    do_trigger(2'd1, 16'd10, 16'sd700, 1'b0);
    trigger_in = 1'b1;
    amplitude_in = 16'sd3;
    mode_in = 2'd3;
    for (int i = 0; i < 5; i++) do_step(16'sd700, (i == 0), 1'b0, 1'b1, "abort_pre");
    abort_in = 1'b1; step_in = 1'b1;
    expect_out('0, 1'b0, 1'b0, 1'b0, "abort");
    clk1();
    step_in = 1'b0;
    check_front();
    // trigger and abort together in IDLE
    expect_out('0, 1'b0, 1'b0, 1'b0, "trig_abort");
    clk1();
    check_front();
    abort_in = 1'b0; trigger_in = 1'b0;
    do_step('0, 1'b0, 1'b0, 1'b0, "abort_idle");

    // Async reset just after the first sample, checked before the next edge
    do_trigger(2'd1, 16'd10, 16'sd500, 1'b0);
    step_in = 1'b1;
    expect_out(16'sd500, 1'b1, 1'b0, 1'b1, "pre_rst");
    clk1();
    step_in = 1'b0;
    check_front();
    #2 rst_in = 1'b1;
    #1;
    expect_out('0, 1'b0, 1'b0, 1'b0, "async_rst");
    check_front();
    #2 rst_in = 1'b0;
    clk1();
    run_burst(2'd3, 16'd2, 16'sd5, 1'b0, "post_rst");

`ifdef SIGGEN_REPEAT_EN
    repeat_in = 1'b1;
    do_trigger(2'd1, 16'd2, 16'sd300, 1'b0);
    repeat_in = 1'b0;
    for (int b = 0; b < 2; b++) begin
      do_step(16'sd300, 1'b1, 1'b0, 1'b1, "rep_s1");
      do_step(16'sd300, 1'b0, 1'b0, 1'b1, "rep_s2");
      do_step('0, 1'b0, 1'b1, 1'b1, "rep_done");
      do_step('0, 1'b0, 1'b0, 1'b1, "rep_gap");
    end
    abort_in = 1'b1;
    expect_out('0, 1'b0, 1'b0, 1'b0, "rep_abort");
    clk1();
    abort_in = 1'b0;
    check_front();
    do_step('0, 1'b0, 1'b0, 1'b0, "rep_idle");
`endif

    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
